// File: rtl/ifu_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
package ifu_pkg;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    WAIT,
    WAIT_DROP,
    STALL
  } iq_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// DEPTH-entry ring buffer of fetch entries with synchronous flush.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t wr_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A push on a full queue is only allowed when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifu_inst_queue.sv
// Fetch-to-decode instruction queue: buffers fetch responses for decode and
// paces the fetch stage so that queued plus outstanding fetches never exceed DEPTH.
module ifu_inst_queue
  import ifu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = ifu_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifetch_inst_vld,
  input  logic [63:0] ifetch_inst_pc,
  input  logic [63:0] ifetch_inst,
  output logic        ifetch_req,
  output logic        ifetch_taken,
  output logic [63:0] ifetch_taken_pc,
  input  logic        redirect_vld,
  input  logic [63:0] redirect_pc,
  output logic        id_vld,
  output logic [63:0] id_pc,
  output logic [31:0] id_inst,
  input  logic        id_rdy
);

  localparam int CW = $clog2(DEPTH) + 1;
  // The boot fetch to RESET_PC is launched by the fetch stage itself.
  localparam logic [63:0] unused_reset_pc = RESET_PC;

  iq_state_e     state, state_nxt;
  logic [63:0]   pend_pc, pend_nxt;
  logic          push, pop, fifo_full, fifo_empty;
  logic [CW-1:0] count, count_nxt;
  fetch_entry_t  head, wr_data;
  logic          unused_inst_hi;

  assign unused_inst_hi = ^ifetch_inst[63:32];

  assign push      = (state == WAIT) & ifetch_inst_vld & ~redirect_vld;
  assign pop       = id_vld & id_rdy & ~redirect_vld;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign wr_data   = '{pc: ifetch_inst_pc, inst: ifetch_inst[31:0]};

  ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .flush   (redirect_vld),
    .head    (head),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign id_vld  = ~fifo_empty;
  assign id_pc   = id_vld ? head.pc   : '0;
  assign id_inst = id_vld ? head.inst : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT;
      pend_pc <= '0;
    end else begin
      state   <= state_nxt;
      pend_pc <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pend_nxt        = pend_pc;
    ifetch_req      = 1'b0;
    ifetch_taken    = 1'b0;
    ifetch_taken_pc = '0;
    case (state)
      WAIT: begin
        if (ifetch_inst_vld) begin
          if (redirect_vld) begin
            ifetch_req      = 1'b1;
            ifetch_taken    = 1'b1;
            ifetch_taken_pc = redirect_pc;
          end else if (count_nxt < CW'(DEPTH)) begin
            ifetch_req = 1'b1;
          end else begin
            state_nxt = STALL;
          end
        end else if (redirect_vld) begin
          pend_nxt  = redirect_pc;
          state_nxt = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        // The stale response only frees the fetch slot; the newest target wins.
        if (ifetch_inst_vld) begin
          ifetch_req      = 1'b1;
          ifetch_taken    = 1'b1;
          ifetch_taken_pc = redirect_vld ? redirect_pc : pend_pc;
          state_nxt       = WAIT;
        end else if (redirect_vld) begin
          pend_nxt = redirect_pc;
        end
      end
      STALL: begin
        if (redirect_vld) begin
          ifetch_req      = 1'b1;
          ifetch_taken    = 1'b1;
          ifetch_taken_pc = redirect_pc;
          state_nxt       = WAIT;
        end else if (count_nxt < CW'(DEPTH)) begin
          ifetch_req = 1'b1;
          state_nxt  = WAIT;
        end
      end
      default: state_nxt = WAIT;
    endcase
  end

  logic [CW:0] occupancy;
  assign occupancy = {1'b0, count} + (CW+1)'(state != STALL);

  a_no_resp_in_stall: assert property (@(posedge clk) disable iff (!rst_n)
    !(state == STALL && ifetch_inst_vld));
  a_occupancy: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= (CW+1)'(DEPTH));
  a_single_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    !(ifetch_req && state != STALL && !ifetch_inst_vld));
  a_no_wait_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_full && state == WAIT));

endmodule

// File: tb/tb_ifu_inst_queue.sv
// Randomized scoreboard bench: a fetch-stage model answers requests, a queue model
// predicts decode entries and fetch requests, and a negedge monitor compares.
module tb_ifu_inst_queue;
  import ifu_pkg::*;

  localparam int DEPTH = 4;
  localparam int NCYC  = 3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifetch_inst_vld;
  logic [63:0] ifetch_inst_pc, ifetch_inst;
  logic        ifetch_req, ifetch_taken;
  logic [63:0] ifetch_taken_pc;
  logic        redirect_vld;
  logic [63:0] redirect_pc;
  logic        id_vld;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
  logic        id_rdy;

  always #5 clk = ~clk;

  ifu_inst_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ifetch_inst_vld (ifetch_inst_vld),
    .ifetch_inst_pc  (ifetch_inst_pc),
    .ifetch_inst     (ifetch_inst),
    .ifetch_req      (ifetch_req),
    .ifetch_taken    (ifetch_taken),
    .ifetch_taken_pc (ifetch_taken_pc),
    .redirect_vld    (redirect_vld),
    .redirect_pc     (redirect_pc),
    .id_vld          (id_vld),
    .id_pc           (id_pc),
    .id_inst         (id_inst),
    .id_rdy          (id_rdy)
  );

  typedef struct {
    bit          req;
    bit          taken;
    logic [63:0] pc;
  } req_t;

  fetch_entry_t exp_q[$];
  req_t         req_q[$];
  int           checks = 0;
  int           errors = 0;
  bit           run = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  bit           m_ev;
  fetch_entry_t m_ent;
  req_t         m_r;
  always @(negedge clk) begin
    if (run) begin
      m_ev = (exp_q.size() != 0);
      chk("id_vld", id_vld, m_ev);
      if (m_ev) begin
        chk("id_pc", id_pc, exp_q[0].pc);
        chk("id_inst", id_inst, exp_q[0].inst);
        if (id_rdy && !redirect_vld) m_ent = exp_q.pop_front();
      end
      if (req_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_q_underflow actual=empty expected=entry t=%0t", $time);
      end else begin
        m_r = req_q.pop_front();
        chk("ifetch_req", ifetch_req, m_r.req);
        chk("ifetch_taken", ifetch_taken, m_r.taken);
        chk("ifetch_taken_pc", ifetch_taken_pc, m_r.pc);
      end
    end
  end

  // Reference model state: one outstanding fetch at most, optionally to be dropped.
  bit           outstanding, keep, resp, redir, rdy, pop, first_resp;
  bit           flush_pend, push_pend;
  fetch_entry_t push_ent;
  logic [63:0]  resp_pc, pend, rpc;
  int           timer, cnt, rdy_pct;
  req_t         e;

  initial begin
    rst_n = 1'b0; ifetch_inst_vld = 1'b0; ifetch_inst_pc = '0; ifetch_inst = '0;
    redirect_vld = 1'b0; redirect_pc = '0; id_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_id_vld", id_vld, 1'b0);
    chk("rst_ifetch_req", ifetch_req, 1'b0);
    chk("rst_ifetch_taken", ifetch_taken, 1'b0);
    chk("rst_ifetch_taken_pc", ifetch_taken_pc, 64'h0);
    chk("rst_id_pc", id_pc, 64'h0);
    chk("rst_id_inst", id_inst, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Fetch stage self-starts the boot fetch.
    outstanding = 1'b1; keep = 1'b1; resp_pc = RESET_PC; timer = 2; first_resp = 1'b1;
    flush_pend = 1'b0; push_pend = 1'b0; pend = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk); #1;
      if (flush_pend) begin exp_q.delete(); flush_pend = 1'b0; end
      if (push_pend)  begin exp_q.push_back(push_ent); push_pend = 1'b0; end
      if (timer > 0) timer--;

      case ((cyc / 25) % 3)
        0:       rdy_pct = 0;
        1:       rdy_pct = 50;
        default: rdy_pct = 90;
      endcase
      resp  = outstanding && (timer == 0);
      redir = (cyc > 10) && ($urandom_range(0, 9) == 0);
      rdy   = ($urandom_range(0, 99) < rdy_pct);
      rpc   = {$urandom, $urandom} & ~64'h3;

      ifetch_inst_vld = resp;
      ifetch_inst_pc  = resp ? resp_pc : {$urandom, $urandom};
      ifetch_inst     = (resp && first_resp) ? 64'h13 : {$urandom, $urandom};
      if (resp) first_resp = 1'b0;
      redirect_vld    = redir;
      redirect_pc     = redir ? rpc : {$urandom, $urandom};
      id_rdy          = rdy;
      run             = 1'b1;

      cnt = exp_q.size();
      pop = rdy && (cnt > 0) && !redir;
      e = '{req: 1'b0, taken: 1'b0, pc: 64'h0};
      if (redir) begin
        flush_pend = 1'b1;
        if (outstanding && !resp) begin
          keep = 1'b0;
          pend = rpc;
        end else
          e = '{req: 1'b1, taken: 1'b1, pc: rpc};
      end else if (resp) begin
        if (keep) begin
          push_pend = 1'b1;
          push_ent  = '{pc: resp_pc, inst: ifetch_inst[31:0]};
          if (cnt + 1 - int'(pop) < DEPTH) e.req = 1'b1;
          else outstanding = 1'b0;
        end else
          e = '{req: 1'b1, taken: 1'b1, pc: pend};
      end else if (!outstanding && (cnt - int'(pop) < DEPTH)) begin
        e.req = 1'b1;
      end
      if (e.req) begin
        outstanding = 1'b1;
        keep        = 1'b1;
        resp_pc     = e.taken ? e.pc : resp_pc + 64'd4;
        timer       = $urandom_range(1, 3);
      end
      req_q.push_back(e);
    end

    @(posedge clk); #1;
    run = 1'b0;
    ifetch_inst_vld = 1'b0; redirect_vld = 1'b0; id_rdy = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
